// File: rtl/subsys_bringup_ctrl_if.sv
// ----------------------------------------------------------------------------
// subsys_bringup_ctrl_if
// Groups the bring-up controller's board/status inputs and its status outputs.
//   master : drives pcie_rst_n, ddr_calib_done, user_lnk_up, lnk_width,
//            fault_clr; observes axi_aresetn, led_o, state_o, fault_o
//   slave  : the controller side (mirror of master)
// ----------------------------------------------------------------------------
interface subsys_bringup_ctrl_if #(
   parameter int NUM_DDR  = 1,
   parameter int NUM_LEDS = 8
);
   logic                pcie_rst_n;
   logic [NUM_DDR-1:0]  ddr_calib_done;
   logic                user_lnk_up;
   logic [3:0]          lnk_width;
   logic                fault_clr;
   logic                axi_aresetn;
   logic [NUM_LEDS-1:0] led_o;
   logic [2:0]          state_o;
   logic                fault_o;

   modport master (
      output pcie_rst_n, ddr_calib_done, user_lnk_up, lnk_width, fault_clr,
      input  axi_aresetn, led_o, state_o, fault_o
   );

   modport slave (
      input  pcie_rst_n, ddr_calib_done, user_lnk_up, lnk_width, fault_clr,
      output axi_aresetn, led_o, state_o, fault_o
   );
endinterface

// File: rtl/subsys_bringup_ctrl.sv
// ----------------------------------------------------------------------------
// subsys_bringup_ctrl
// Sequences subsystem bring-up: waits for PERST# release, DDR calibration and
// PCIe link-up, then releases the AXI fabric reset. Loss of calibration or
// link afterwards latches a fault code until acknowledged.
//   sys_clk   : sole clock, rising edge
//   sys_reset : asynchronous active-high reset
//   bus       : slave side of subsys_bringup_ctrl_if (board inputs in,
//               axi_aresetn / led_o / state_o / fault_o out, all registered)
// Fault codes: 1 calib timeout, 2 link timeout, 3 link lost, 4 calib lost.
// ----------------------------------------------------------------------------
module subsys_bringup_ctrl #(
   parameter int NUM_DDR     = 1,
   parameter int NUM_LEDS    = 8,
   parameter int EXP_LANES   = 8,
   parameter int TIMEOUT_CYC = 2**24,
   parameter int HB_DIV      = 2**25
) (
   input  logic                  sys_clk,
   input  logic                  sys_reset,
   subsys_bringup_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_CAL  = 3'd1,
      ST_WAIT_LINK = 3'd2,
      ST_RUN       = 3'd3,
      ST_DEGRADED  = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   localparam int             TW    = $clog2(TIMEOUT_CYC);
   localparam int             HW    = $clog2(HB_DIV);
   localparam logic [TW-1:0]  T_MAX = TW'(TIMEOUT_CYC - 1);
   localparam logic [HW-1:0]  H_MAX = HW'(HB_DIV - 1);
   localparam logic [3:0]     EXP_W = 4'(EXP_LANES);

   state_t              state, state_nxt;
   logic [TW-1:0]       timer, timer_nxt;
   logic [2:0]          code, code_nxt;
   logic [HW-1:0]       hb_cnt, hb_cnt_nxt;
   logic                hb, hb_nxt;
   logic                perst_meta, perst_s;
   logic                calib_all;
   logic [3:0]          led_hi;
   logic [NUM_LEDS-1:0] led_nxt, led_q;
   logic                axi_q, fault_q;

   assign calib_all = &bus.ddr_calib_done;

   always_comb begin
      state_nxt = state;
      code_nxt  = code;
      if (!perst_s) begin
         // PERST# asserted overrides everything, including a latched fault
         state_nxt = ST_RESET;
         code_nxt  = 3'd0;
      end else begin
         case (state)
            ST_RESET:     state_nxt = ST_WAIT_CAL;
            ST_WAIT_CAL: begin
               if (calib_all) state_nxt = ST_WAIT_LINK;
               else if (timer == T_MAX) begin
                  state_nxt = ST_FAULT;
                  code_nxt  = 3'd1;
               end
            end
            ST_WAIT_LINK: begin
               if (bus.user_lnk_up)
                  state_nxt = (bus.lnk_width >= EXP_W) ? ST_RUN : ST_DEGRADED;
               else if (timer == T_MAX) begin
                  state_nxt = ST_FAULT;
                  code_nxt  = 3'd2;
               end
            end
            ST_RUN, ST_DEGRADED: begin
               // calibration loss is the more severe cause, report it first
               if (!calib_all) begin
                  state_nxt = ST_FAULT;
                  code_nxt  = 3'd4;
               end else if (!bus.user_lnk_up) begin
                  state_nxt = ST_FAULT;
                  code_nxt  = 3'd3;
               end
            end
            ST_FAULT: begin
               if (bus.fault_clr) begin
                  state_nxt = ST_RESET;
                  code_nxt  = 3'd0;
               end
            end
            default: begin
               state_nxt = ST_RESET;
               code_nxt  = 3'd0;
            end
         endcase
      end

      // timer saturates rather than wrapping; it only runs while waiting
      timer_nxt = timer;
      if (state_nxt != state) timer_nxt = '0;
      else if ((state == ST_WAIT_CAL || state == ST_WAIT_LINK) && timer != T_MAX)
         timer_nxt = timer + TW'(1);

      hb_nxt     = hb;
      hb_cnt_nxt = hb_cnt + HW'(1);
      if (hb_cnt == H_MAX) begin
         hb_cnt_nxt = '0;
         hb_nxt     = ~hb;
      end

      // LEDs are built from next-state values so they line up with state_o
      led_hi = (state_nxt == ST_FAULT) ? {1'b0, code_nxt} : bus.lnk_width;
      led_nxt    = '0;
      led_nxt[0] = hb_nxt;
      led_nxt[1] = calib_all;
      led_nxt[2] = bus.user_lnk_up;
      led_nxt[3] = (state_nxt == ST_RUN) | ((state_nxt == ST_DEGRADED) & hb_nxt);
      for (int i = 4; i < NUM_LEDS; i++)
         led_nxt[i] = |(led_hi & (4'd1 << (i - 4)));
   end

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         perst_meta <= 1'b0;
         perst_s    <= 1'b0;
         state      <= ST_RESET;
         timer      <= '0;
         code       <= 3'd0;
         hb_cnt     <= '0;
         hb         <= 1'b0;
         axi_q      <= 1'b0;
         fault_q    <= 1'b0;
         led_q      <= '0;
      end else begin
         perst_meta <= bus.pcie_rst_n;
         perst_s    <= perst_meta;
         state      <= state_nxt;
         timer      <= timer_nxt;
         code       <= code_nxt;
         hb_cnt     <= hb_cnt_nxt;
         hb         <= hb_nxt;
         axi_q      <= (state_nxt == ST_RUN) || (state_nxt == ST_DEGRADED);
         fault_q    <= (state_nxt == ST_FAULT);
         led_q      <= led_nxt;
      end
   end

   assign bus.state_o     = state;
   assign bus.axi_aresetn = axi_q;
   assign bus.fault_o     = fault_q;
   assign bus.led_o       = led_q;
endmodule
